// File: rtl/ones_count_accumulator_pkg.sv
// Shared types and constants for the ones-count accumulator.
// Contents: FSM state encoding, per-word maximum count, count width.
// Imported by the interface and the top module.
package ones_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest count a 7-input ones counter can produce.
  localparam int MAX_PER_WORD = 7;
  // Width of one count (y2..y0 of the ones counter).
  localparam int CNT_W = 3;

endpackage

// File: rtl/ones_count_accumulator_if.sv
// Bus between the ones counter / sequencer and the accumulator.
// Upstream side (master) drives start, cnt_in and cnt_valid.
// Accumulator side (slave) drives cnt_ready, busy, done, sum_out and majority.
interface ones_count_accumulator_if
  import ones_acc_pkg::*;
#(
  parameter int SUM_W = 6
);
  logic             start;
  logic [CNT_W-1:0] cnt_in;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum_out;
  logic             majority;

  modport master (
    output start, cnt_in, cnt_valid,
    input  cnt_ready, busy, done, sum_out, majority
  );

  modport slave (
    input  start, cnt_in, cnt_valid,
    output cnt_ready, busy, done, sum_out, majority
  );
endinterface

// File: rtl/ones_count_accumulator_word_counter.sv
// Mod-WORDS word index counter with synchronous clear and count enable.
// Ports: i_clk, i_rst (sync, active-high), i_clr, i_en -> o_tc.
// o_tc is high while the index sits at WORDS-1 (the last word of a frame).
module word_counter #(
  parameter int WORDS = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  // A single-word frame still needs a 1-bit register.
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  logic [IDX_W-1:0] r_idx;
  logic             w_tc;

  assign w_tc = (r_idx == LAST);
  assign o_tc = w_tc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      // Wrap at the terminal count so non-power-of-two frames work.
      r_idx <= w_tc ? '0 : r_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/ones_count_accumulator.sv
// Accumulates WORDS ones-counts per frame; reports total + majority with a done pulse.
// Ports: i_clk, i_rst (sync, active-high), bus (slave side of ones_count_accumulator_if).
// done follows the last accepted word by one cycle; cnt_ready is high only in ACCUM.
module ones_count_accumulator
  import ones_acc_pkg::*;
#(
  parameter int WORDS = 8,
  parameter int SUM_W = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  ones_count_accumulator_if.slave  bus
);
  localparam int CMP_W = SUM_W + 4;
  // Majority threshold: strictly more than half of the maximum possible total.
  localparam logic [CMP_W-1:0] THRESH = CMP_W'(MAX_PER_WORD * WORDS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_sum;
  logic             r_maj;
  logic [SUM_W-1:0] w_total;
  logic [CMP_W-1:0] w_twice;
  logic             w_maj;
  logic             w_accept;
  logic             w_clr;
  logic             w_last;
  logic             w_ready;
  logic             w_busy;
  logic             w_done;

  // Running total including the word offered this cycle; this is also the
  // frame result when the offered word is the last one.
  assign w_total = r_acc + SUM_W'(bus.cnt_in);
  assign w_twice = CMP_W'(w_total) << 1;
  assign w_maj   = (w_twice > THRESH);

  word_counter #(
    .WORDS (WORDS)
  ) u_word_counter (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_clr),
    .i_en  (w_accept),
    .o_tc  (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = ACCUM;
          w_clr       = 1'b1;
        end
      end
      ACCUM: begin
        w_ready  = 1'b1;
        w_busy   = 1'b1;
        w_accept = bus.cnt_valid;
        if (bus.cnt_valid && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_sum   <= '0;
      r_maj   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_acc <= '0;
      end else if (w_accept) begin
        r_acc <= w_total;
      end
      if (w_accept && w_last) begin
        r_sum <= w_total;
        r_maj <= w_maj;
      end
    end
  end

  assign bus.cnt_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.sum_out   = r_sum;
  assign bus.majority  = r_maj;
endmodule

// File: doc/ones_count_accumulator.md
Name: ones_count_accumulator

Overview:
- Downstream stage of the 7-input ones counter: consumes its 3-bit count (0..7) once per accepted word.
- Accumulates counts over a frame of WORDS words, then presents the frame total and a majority flag with a one-cycle done pulse.
- Uses a valid/ready handshake on the input side and a start/busy/done control interface toward the sequencing logic.

Parameters:
- WORDS, 8, number of 7-bit words (counts) per frame; legal range 1..64.
- SUM_W, 6, width of the frame total; must satisfy 2^SUM_W > 7*WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a frame; sampled only in IDLE.
- cnt_in  input  3  ones count of the current word (y2..y0 of the ones counter).
- cnt_valid  input  1  cnt_in carries a valid count this cycle.
- cnt_ready  output  1  block accepts cnt_in this cycle.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse: sum_out and majority are updated.
- sum_out  output  SUM_W  total ones across the last completed frame.
- majority  output  1  high when 2*sum_out > 7*WORDS.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; accumulator=0; word index=0.
  - Outputs after reset: sum_out=0, majority=0, done=0, busy=0, cnt_ready=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - cnt_ready=0, busy=0.
  - On start=1: next state ACCUM; accumulator and word index cleared.
  - sum_out and majority hold the previous frame's result.
- ACCUM:
  - cnt_ready=1, busy=1.
  - Accept = cnt_valid & cnt_ready. On accept: accumulator += cnt_in (zero-extended to SUM_W); word index += 1.
  - Cycles with cnt_valid=0 change nothing.
  - Accept while word index==WORDS-1: next state DONE; sum_out <= accumulator+cnt_in; majority computed from that same value.
- DONE:
  - Exactly one cycle; done=1, busy=1, cnt_ready=0.
  - Next state IDLE.
  - Latency: done is high in the cycle after the last word is accepted.
- start in ACCUM or DONE is ignored. The earliest new frame begins from start sampled in the IDLE cycle following DONE.
- cnt_valid while cnt_ready=0 (IDLE/DONE): the word is not consumed and has no effect. The upstream must hold it until ready.
- Arithmetic: no overflow is possible under the SUM_W constraint. Majority compare is done in SUM_W+4 bits, unsigned.
- rst mid-frame: the frame is abandoned and all state returns to reset values, including sum_out=0.
- WORDS=1: ACCUM accepts one word, then goes to DONE.

Decomposition:
- Package ones_acc_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - constant MAX_PER_WORD=7.
  - constant CNT_W=3.
- Sub-module word_counter:
  - Parameterised mod-WORDS counter with clear, enable and terminal-count output.
  - Instantiated once for the word index.
- All other logic stays in the top module.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with random inputs -> sum_out=0, majority=0, done=0, busy=0, cnt_ready=0.
2. Full frame: start, then 8 back-to-back accepts of cnt_in=7 -> done high exactly 1 cycle after the 8th accept, sum_out=56, majority=1, busy low the following cycle.
3. Gapped input: counts 0,1,2,3,4,5,6,7 with cnt_valid low on alternate cycles (garbage cnt_in during gaps) -> sum_out=28, majority=0 (56 not > 56); done 1 cycle after the final accept.
4. Idle rejection: cnt_valid=1, cnt_in=5 for 5 cycles in IDLE, no start -> cnt_ready=0 throughout, sum_out and done unchanged. Start during ACCUM is also ignored (frame completes after 8 accepts, not restarted).
5. Reset mid-frame: 4 words of 6 accepted, then rst for 1 cycle -> all outputs 0. A new frame of 8×3 gives sum_out=24, majority=0.
6. Back-to-back frames: start held high continuously, frame A (8×7) then frame B (8×1) -> done pulses twice; sum_out=56 then 8. Frame B starts only via the IDLE cycle after DONE.
